rv32i_encoder: RTL

//  Inverse of the DECODE stage: packs instruction fields (op class, rd/rs1/rs2, funct3, alt bit, 32b imm) into a 32-bit RV32I word.

---
 rtl/rv32i_pkg.sv | 40 ++++
 rtl/rv32i_enc_fifo.sv | 65 ++++++
 rtl/rv32i_encoder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: base opcodes (common with the decode stage),
// encoder op-class codes and funct3 codes used by the encoder.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [3:0] {
    OP_RTYPE  = 4'd0,
    OP_ITYPE  = 4'd1,
    OP_LOAD   = 4'd2,
    OP_STORE  = 4'd3,
    OP_BRANCH = 4'd4,
    OP_JAL    = 4'd5,
    OP_JALR   = 4'd6,
    OP_LUI    = 4'd7,
    OP_AUIPC  = 4'd8,
    OP_SYSTEM = 4'd9,
    OP_FENCE  = 4'd10
  } op_class_e;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  // Shift-immediate forms carry a shamt in imm[4:0] instead of a 12-bit imm.
  function automatic logic is_shift_f3(input logic [2:0] f3);
    return (f3 == F3_SLL) || (f3 == F3_SRL_SRA);
  endfunction

endpackage

// File: rtl/rv32i_enc_fifo.sv
// Two-entry FIFO for encoder results. Occupancy is registered so that the
// full flag never depends combinationally on the downstream ready.
module rv32i_enc_fifo #(
  parameter int unsigned DW = 65
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_pop,
  output logic [DW-1:0] o_rdata,
  output logic          o_full,
  output logic          o_empty
);

  logic [1:0][DW-1:0] mem_q, mem_d;
  logic               wr_q, wr_d;
  logic               rd_q, rd_d;
  logic [1:0]         cnt_q, cnt_d;

  logic push_ok, pop_ok;

  assign push_ok = i_push && (cnt_q != 2'd2);
  assign pop_ok  = i_pop && (cnt_q != 2'd0);

  assign o_rdata = mem_q[rd_q];
  assign o_full  = (cnt_q == 2'd2);
  assign o_empty = (cnt_q == 2'd0);

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) begin
      mem_d[wr_q] = i_wdata;
      wr_d        = ~wr_q;
    end
    if (pop_ok) begin
      rd_d = ~rd_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO state registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mem_q <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rv32i_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word, tags it
// with an auto-incrementing byte address and queues it in a 2-entry FIFO.
// Optional legality checking is enabled by defining RV32I_ENCODER_CHECK_EN.
module rv32i_encoder
  import rv32i_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [3:0]        i_op,
  input  logic [2:0]        i_funct3,
  input  logic              i_alt,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [31:0]       i_imm,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [31:0]       o_inst,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_err,
  output logic [CNT_W-1:0]  o_count
);

  localparam int unsigned DW = 32 + ADDR_W + 1;

  logic              accept, pop;
  logic              fifo_full, fifo_empty;
  logic [DW-1:0]     fifo_wdata, fifo_rdata;
  logic [31:0]       enc_inst;
  logic              enc_err;
  logic [ADDR_W-1:0] base_al, entry_addr;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign o_ready = ~fifo_full;
  assign o_valid = ~fifo_empty;
  assign accept  = i_valid & o_ready;
  assign pop     = o_valid & i_ready;

  // Field packing per instruction format; unused fields stay zero
  always_comb begin
    enc_inst = '0;
    case (op_class_e'(i_op))
      OP_RTYPE:  enc_inst = {1'b0, i_alt, 5'b0, i_rs2, i_rs1, i_funct3, i_rd, OPC_OP};
      OP_ITYPE: begin
        if (is_shift_f3(i_funct3))
          enc_inst = {1'b0, i_alt, 5'b0, i_imm[4:0], i_rs1, i_funct3, i_rd, OPC_OP_IMM};
        else
          enc_inst = {i_imm[11:0], i_rs1, i_funct3, i_rd, OPC_OP_IMM};
      end
      OP_LOAD:   enc_inst = {i_imm[11:0], i_rs1, i_funct3, i_rd, OPC_LOAD};
      OP_JALR:   enc_inst = {i_imm[11:0], i_rs1, i_funct3, i_rd, OPC_JALR};
      OP_SYSTEM: enc_inst = {i_imm[11:0], i_rs1, i_funct3, i_rd, OPC_SYSTEM};
      OP_FENCE:  enc_inst = {i_imm[11:0], i_rs1, i_funct3, i_rd, OPC_MISC_MEM};
      OP_STORE:  enc_inst = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OPC_STORE};
      OP_BRANCH: enc_inst = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                             i_imm[4:1], i_imm[11], OPC_BRANCH};
      OP_JAL:    enc_inst = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OPC_JAL};
      OP_LUI:    enc_inst = {i_imm[31:12], i_rd, OPC_LUI};
      OP_AUIPC:  enc_inst = {i_imm[31:12], i_rd, OPC_AUIPC};
      default:   enc_inst = '0;
    endcase
  end

`ifdef RV32I_ENCODER_CHECK_EN
  logic signed [31:0] imm_s;
  assign imm_s = i_imm;

  // Legality check on the immediate range/alignment of the offered fields
  always_comb begin
    enc_err = 1'b0;
    case (op_class_e'(i_op))
      OP_RTYPE, OP_SYSTEM, OP_FENCE: enc_err = 1'b0;
      OP_ITYPE: begin
        if (is_shift_f3(i_funct3))
          enc_err = (i_imm[31:5] != '0);
        else
          enc_err = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      end
      OP_LOAD, OP_JALR, OP_STORE:
        enc_err = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      OP_BRANCH:
        enc_err = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || i_imm[0];
      OP_JAL:
        enc_err = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || i_imm[0];
      OP_LUI, OP_AUIPC:
        enc_err = (i_imm[11:0] != '0);
      default: enc_err = 1'b1;
    endcase
  end
`else
  assign enc_err = 1'b0;
`endif

  // Address pointer: start reloads it (word-aligned), each accept advances it;
  // a start in the same cycle as an accept tags the entry with the new base.
  always_comb begin
    base_al    = {i_base_addr[ADDR_W-1:2], 2'b00};
    entry_addr = i_start ? base_al : ptr_q;
    ptr_d      = i_start ? base_al : ptr_q;
    if (accept) ptr_d = entry_addr + ADDR_W'(4);
  end

  // Pop counter, wraps naturally
  always_comb begin
    cnt_d = cnt_q;
    if (pop) cnt_d = cnt_q + CNT_W'(1);
  end

  // Pointer and counter registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  assign fifo_wdata = {enc_inst, entry_addr, enc_err};

  rv32i_enc_fifo #(
    .DW (DW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (accept),
    .i_wdata (fifo_wdata),
    .i_pop   (pop),
    .o_rdata (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign o_inst  = fifo_rdata[DW-1 -: 32];
  assign o_addr  = fifo_rdata[ADDR_W:1];
  assign o_err   = fifo_rdata[0];
  assign o_count = cnt_q;

endmodule
